param_johnson_counter: RTL and testbench
========================================

PARAM_JOHNSON_COUNTER -- requirements
Module: param_johnson_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width, legal range 2..32.
REQ-002 SHALL have parameter DIV_W, default 8, prescaler divisor width, legal range 1..16.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable; prescaler advances only when high.
REQ-006 SHALL have port dir  input  1  1 = forward step, 0 = reverse step.
REQ-007 SHALL have port mode  input  1  0 = Johnson (twisted-ring) code, 1 = ring (one-hot) code.
REQ-008 SHALL have port div  input  DIV_W  prescaler divisor; a step occurs every div+1 enabled cycles.
REQ-009 SHALL have port load  input  1  synchronous load strobe.
REQ-010 SHALL have port load_val  input  WIDTH  value written to q on load.
REQ-011 SHALL have port q  output  WIDTH  counter state, registered.
REQ-012 SHALL have port idx  output  $clog2(2*WIDTH)  sequence position of q, registered.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse on sequence wrap, registered.
REQ-014 SHALL have port err  output  1  one-cycle pulse on illegal-state correction, registered.

Function
REQ-015 Johnson forward step SHALL be q <= {q[WIDTH-2:0], ~q[WIDTH-1]}; reverse SHALL be q <= {~q[0], q[WIDTH-1:1]}; period 2*WIDTH.
REQ-016 Ring forward step SHALL be rotate-left by 1; reverse SHALL be rotate-right by 1; period WIDTH.
REQ-017 Seed SHALL be all-zeros (Johnson) or 1 (ring), idx 0.
REQ-018 Johnson idx SHALL be k for q=(2^k)-1, k=0..WIDTH, and WIDTH+j for q = all-ones with low j bits cleared, j=1..WIDTH-1; ring idx SHALL be the position of the set bit.
REQ-019 Internal prescaler pre (DIV_W bits) SHALL: hold when en=0; when en=1 and pre>=div, issue step and clear to 0; else increment.
REQ-020 div=0 SHALL step on every enabled cycle; lowering div below pre SHALL step on next enabled cycle.
REQ-021 Per-cycle priority SHALL be rst > load > mode change > step > hold.
REQ-022 load SHALL write load_val to q, compute idx, clear pre; if load_val is not a legal code for the current mode, q SHALL take the seed and err SHALL pulse.
REQ-023 A change of mode versus its registered previous value SHALL force q to the new mode's seed, idx 0, clear pre, no err, no wrap.
REQ-024 On a step, if q is illegal for the current mode (e.g. SEU), q SHALL take the seed instead of stepping, err SHALL pulse, wrap SHALL stay 0.
REQ-025 wrap SHALL pulse for the cycle after a forward step from last idx to 0 or a reverse step from 0 to last idx; never on load or seed reload.
REQ-026 dir SHALL be sampled per step; reversing mid-sequence SHALL retrace without skipping codes.
REQ-027 All outputs SHALL update one clock after the qualifying edge; no combinational input-to-output path.

Reset
REQ-028 rst=1 at a clock edge SHALL set q=seed of current mode, idx=0, pre=0, wrap=0, err=0, registered mode=mode, overriding load and en.
REQ-029 rst asserted mid-sequence SHALL take effect at that edge; first step after release SHALL occur after div+1 enabled cycles.

Verification (WIDTH=4, DIV_W=4)
REQ-030 mode=0, dir=1, div=0, en=1 for 8 cycles from reset -> q 0001,0011,0111,1111,1110,1100,1000,0000; wrap=1 only with final 0000.
REQ-031 mode=0, div=2, en=1 -> q changes every 3rd cycle; en=0 for 5 cycles mid-count -> q and pre frozen, then resume with correct remaining phase.
REQ-032 mode=0, load=1, load_val=0101 -> next cycle q=0000, idx=0, err=1 one cycle; load_val=1100 -> q=1100, idx=6, err=0.
REQ-033 mode=1, dir=0, div=0 from reset -> q 1000,0100,0010,0001; wrap=1 with first 1000; switch mode to 0 -> q=0000, idx=0, no err.
REQ-034 q forced to 1011 in Johnson mode, then one step -> q=0000, err=1, wrap=0; dir toggled at idx=3 -> idx 2,1,0 sequence.
REQ-035 rst and load asserted together with load_val=0111 -> q=0000, idx=0; deassert, div=0 -> first step to 0001 on next enabled cycle.

Source files
------------

// File: rtl/param_johnson_counter.sv
// Prescaled bidirectional Johnson / ring counter with a synchronous load and
// self-correction of illegal codes back to the active mode's seed.
module param_johnson_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          dir,
  input  logic                          mode,
  input  logic [DIV_W-1:0]              div,
  input  logic                          load,
  input  logic [WIDTH-1:0]              load_val,
  output logic [WIDTH-1:0]              q,
  output logic [$clog2(2*WIDTH)-1:0]    idx,
  output logic                          wrap,
  output logic                          err
);

  localparam int unsigned IDX_W = $clog2(2*WIDTH);

  logic [DIV_W-1:0] pre, pre_nxt;
  logic             mode_q;
  logic [WIDTH-1:0] q_nxt, seed;
  logic [IDX_W-1:0] idx_nxt, last_idx, cur_idx;
  logic             wrap_nxt, err_nxt;
  logic [IDX_W:0]   cur_dec, ld_dec;

  // Returns {legal, position} of a code under the given mode.
  function automatic logic [IDX_W:0] decode(input logic [WIDTH-1:0] v, input logic m);
    logic [WIDTH-1:0] ones;
    logic [IDX_W:0]   res;
    ones = '1;
    res  = '0;
    if (m) begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        if (v[b]) res[IDX_W-1:0] = IDX_W'(b);
      end
      res[IDX_W] = $onehot(v);
    end else begin
      for (int unsigned k = 0; k <= WIDTH; k++) begin
        if (v == (ones >> (WIDTH - k))) res = {1'b1, IDX_W'(k)};
      end
      for (int unsigned j = 1; j < WIDTH; j++) begin
        if (v == (ones << j)) res = {1'b1, IDX_W'(WIDTH + j)};
      end
    end
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] next_code(input logic [WIDTH-1:0] v, input logic m,
                                                 input logic fwd);
    logic [WIDTH-1:0] r;
    if (fwd) r = {v[WIDTH-2:0], m ? v[WIDTH-1] : ~v[WIDTH-1]};
    else     r = {m ? v[0] : ~v[0], v[WIDTH-1:1]};
    return r;
  endfunction

  always_comb begin
    seed     = mode ? WIDTH'(1) : '0;
    last_idx = mode ? IDX_W'(WIDTH - 1) : IDX_W'(2*WIDTH - 1);
    cur_dec  = decode(q, mode);
    ld_dec   = decode(load_val, mode);
    cur_idx  = cur_dec[IDX_W-1:0];
  end

  // Next state: load > mode change > step > hold.
  always_comb begin
    q_nxt    = q;
    idx_nxt  = idx;
    pre_nxt  = pre;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (load) begin
      pre_nxt = '0;
      if (ld_dec[IDX_W]) begin
        q_nxt   = load_val;
        idx_nxt = ld_dec[IDX_W-1:0];
      end else begin
        q_nxt   = seed;
        idx_nxt = '0;
        err_nxt = 1'b1;
      end
    end else if (mode != mode_q) begin
      q_nxt   = seed;
      idx_nxt = '0;
      pre_nxt = '0;
    end else if (en) begin
      if (pre >= div) begin
        pre_nxt = '0;
        if (!cur_dec[IDX_W]) begin
          q_nxt   = seed;
          idx_nxt = '0;
          err_nxt = 1'b1;
        end else if (dir) begin
          q_nxt    = next_code(q, mode, 1'b1);
          idx_nxt  = (cur_idx == last_idx) ? '0 : IDX_W'(cur_idx + 1'b1);
          wrap_nxt = (cur_idx == last_idx);
        end else begin
          q_nxt    = next_code(q, mode, 1'b0);
          idx_nxt  = (cur_idx == '0) ? last_idx : IDX_W'(cur_idx - 1'b1);
          wrap_nxt = (cur_idx == '0);
        end
      end else begin
        pre_nxt = pre + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (rst) begin
      q    <= seed;
      idx  <= '0;
      pre  <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      q    <= q_nxt;
      idx  <= idx_nxt;
      pre  <= pre_nxt;
      wrap <= wrap_nxt;
      err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_param_johnson_counter.sv
// Bench for param_johnson_counter (WIDTH=4, DIV_W=4): directed vector table,
// hand-written corner sequences, then random traffic against a sequence-list model.
module tb_param_johnson_counter;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst, en, dir, mode, load;
  logic [3:0] div, load_val;
  logic [3:0] q;
  logic [2:0] idx;
  logic       wrap, err;

  int errors = 0;
  int checks = 0;

  param_johnson_counter #(.WIDTH(4), .DIV_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .div(div),
    .load(load), .load_val(load_val), .q(q), .idx(idx), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, dir, mode;
    logic [3:0] div;
    logic       load;
    logic [3:0] lv;
    logic [3:0] eq;
    logic [2:0] eidx;
    logic       ewrap, eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, e, d, m, input logic [3:0] dv, input logic ld,
                     input logic [3:0] lv, eq, input logic [2:0] ei, input logic ew, ee);
    vec_t v;
    v.rst = r; v.en = e; v.dir = d; v.mode = m; v.div = dv; v.load = ld; v.lv = lv;
    v.eq = eq; v.eidx = ei; v.ewrap = ew; v.eerr = ee;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, e, d, m, input logic [3:0] dv, input logic ld,
                       input logic [3:0] lv);
    rst = r; en = e; dir = d; mode = m; div = dv; load = ld; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  // Reference model: codes listed by sequence position.
  function automatic int period(input bit m);
    return m ? W : 2*W;
  endfunction

  function automatic logic [3:0] code_at(input int p, input bit m);
    if (m) return 4'(1 << p);
    if (p <= W) return 4'((1 << p) - 1);
    return 4'(((1 << W) - 1) - ((1 << (p - W)) - 1));
  endfunction

  function automatic int pos_of(input logic [3:0] v, input bit m);
    for (int p = 0; p < period(m); p++) if (code_at(p, m) == v) return p;
    return -1;
  endfunction

  logic [3:0] m_q;
  bit         m_mode, m_wrap, m_err;
  int         m_pre;

  task automatic model_cycle(input bit r, e, d, md, input int dv, input bit ld, input logic [3:0] lv);
    int p;
    m_wrap = 0;
    m_err  = 0;
    if (r) begin
      m_q = code_at(0, md); m_pre = 0;
    end else if (ld) begin
      m_pre = 0;
      if (pos_of(lv, md) >= 0) m_q = lv;
      else begin m_q = code_at(0, md); m_err = 1; end
    end else if (md != m_mode) begin
      m_q = code_at(0, md); m_pre = 0;
    end else if (e) begin
      if (m_pre >= dv) begin
        m_pre = 0;
        p = pos_of(m_q, md);
        if (p < 0) begin m_q = code_at(0, md); m_err = 1; end
        else if (d) begin
          m_wrap = (p == period(md) - 1);
          m_q = code_at((p + 1) % period(md), md);
        end else begin
          m_wrap = (p == 0);
          m_q = code_at((p + period(md) - 1) % period(md), md);
        end
      end else m_pre++;
    end
    m_mode = md;
  endtask

  initial begin
    rst = 1; en = 0; dir = 1; mode = 0; div = 0; load = 0; load_val = 0;

    // Johnson forward from reset, wrap on the return to 0000
    add(1,0,1,0,0,0,0, 4'b0000,0,0,0);
    add(0,1,1,0,0,0,0, 4'b0001,1,0,0);
    add(0,1,1,0,0,0,0, 4'b0011,2,0,0);
    add(0,1,1,0,0,0,0, 4'b0111,3,0,0);
    add(0,1,1,0,0,0,0, 4'b1111,4,0,0);
    add(0,1,1,0,0,0,0, 4'b1110,5,0,0);
    add(0,1,1,0,0,0,0, 4'b1100,6,0,0);
    add(0,1,1,0,0,0,0, 4'b1000,7,0,0);
    add(0,1,1,0,0,0,0, 4'b0000,0,1,0);
    // Loads: illegal then legal
    add(0,0,1,0,0,1,4'b0101, 4'b0000,0,0,1);
    add(0,0,1,0,0,1,4'b1100, 4'b1100,6,0,0);
    // Ring reverse from reset, then mode switch
    add(1,0,0,1,0,0,0, 4'b0001,0,0,0);
    add(0,1,0,1,0,0,0, 4'b1000,3,1,0);
    add(0,1,0,1,0,0,0, 4'b0100,2,0,0);
    add(0,1,0,1,0,0,0, 4'b0010,1,0,0);
    add(0,1,0,1,0,0,0, 4'b0001,0,0,0);
    add(0,1,0,0,0,0,0, 4'b0000,0,0,0);
    // Direction reversal at idx 3, then reverse wrap from 0 to last
    add(0,1,1,0,0,0,0, 4'b0001,1,0,0);
    add(0,1,1,0,0,0,0, 4'b0011,2,0,0);
    add(0,1,1,0,0,0,0, 4'b0111,3,0,0);
    add(0,1,0,0,0,0,0, 4'b0011,2,0,0);
    add(0,1,0,0,0,0,0, 4'b0001,1,0,0);
    add(0,1,0,0,0,0,0, 4'b0000,0,0,0);
    add(0,1,0,0,0,0,0, 4'b1000,7,1,0);

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].dir, tbl[i].mode, tbl[i].div, tbl[i].load, tbl[i].lv);
      check($sformatf("vec%0d.q", i), int'(q), int'(tbl[i].eq));
      check($sformatf("vec%0d.idx", i), int'(idx), int'(tbl[i].eidx));
      check($sformatf("vec%0d.wrap", i), int'(wrap), int'(tbl[i].ewrap));
      check($sformatf("vec%0d.err", i), int'(err), int'(tbl[i].eerr));
    end

    // Prescaler div=2 with an en=0 freeze mid-count
    apply(1,0,1,0,2,0,0);
    apply(0,1,1,0,2,0,0);
    apply(0,1,1,0,2,0,0);
    check("pre.hold2", int'(q), 0);
    apply(0,1,1,0,2,0,0);
    check("pre.step3", int'(q), 1);
    apply(0,1,1,0,2,0,0);
    for (int i = 0; i < 5; i++) apply(0,0,1,0,2,0,0);
    check("pre.frozen", int'(q), 1);
    apply(0,1,1,0,2,0,0);
    check("pre.resume1", int'(q), 1);
    apply(0,1,1,0,2,0,0);
    check("pre.resume2", int'(q), 3);

    // Illegal code corruption corrected on the next step
    rst = 0; en = 1; dir = 1; mode = 0; div = 0; load = 0;
    force dut.q = 4'b1011;
    #1;
    release dut.q;
    @(posedge clk);
    #1;
    check("seu.q", int'(q), 0);
    check("seu.err", int'(err), 1);
    check("seu.wrap", int'(wrap), 0);
    apply(0,1,1,0,0,0,0);
    check("seu.after_q", int'(q), 1);
    check("seu.after_err", int'(err), 0);

    // Reset beats load; first step right after release with div=0
    apply(1,0,1,0,0,1,4'b0111);
    check("rstld.q", int'(q), 0);
    check("rstld.idx", int'(idx), 0);
    apply(0,1,1,0,0,0,0);
    check("rstld.step", int'(q), 1);

    // Randomized traffic against the model
    begin
      bit r, e, d, md, ld;
      int dv;
      logic [3:0] lv;
      md = 0;
      apply(1,0,1,0,0,0,0);
      model_cycle(1,0,1,0,0,0,0);
      for (int c = 0; c < 3000; c++) begin
        r  = ($urandom % 64) == 0;
        ld = ($urandom % 16) == 0;
        if (($urandom % 32) == 0) md = ~md;
        e  = ($urandom % 4) != 0;
        d  = 1'($urandom);
        dv = (($urandom % 8) == 0) ? int'($urandom % 16) : int'($urandom % 4);
        lv = ($urandom % 2) ? code_at(int'($urandom % period(md)), md) : 4'($urandom);
        model_cycle(r, e, d, md, dv, ld, lv);
        apply(r, e, d, md, 4'(dv), ld, lv);
        check($sformatf("rnd%0d.q", c), int'(q), int'(m_q));
        check($sformatf("rnd%0d.idx", c), int'(idx), pos_of(m_q, md));
        check($sformatf("rnd%0d.wrap", c), int'(wrap), int'(m_wrap));
        check($sformatf("rnd%0d.err", c), int'(err), int'(m_err));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
